// File: rtl/seven_seg_counter.sv
// Four-digit BCD up/down counter driven by rising edges of Clk_Slow, with a
// multiplexed active-low seven-segment scan. Define SEG_LZ_BLANK_EN for leading-zero blanking.
module seven_seg_counter #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Clk_Slow,
  input  logic        en,
  input  logic        clr,
  input  logic        up_dn,
  output logic [15:0] count,
  output logic        wrap,
  output logic [6:0]  SEG,
  output logic [3:0]  AN
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              slow_q;
  logic              tick;
  logic [16:0]       step;
  logic [15:0]       count_nxt;
  logic              wrap_nxt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [3:0]        nibble;
  logic              blank;
  logic [6:0]        seg_nxt;
  logic [3:0]        an_nxt;

  // One BCD increment/decrement with ripple carry/borrow; bit 16 is the wrap-out.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
            c = 1'b1;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
            c = 1'b1;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // slow_q resets high so a Clk_Slow already high at reset release is not a tick.
  assign tick = Clk_Slow & ~slow_q;

  always_comb begin
    step      = bcd_step(count, up_dn);
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (tick && en) begin
      count_nxt = step[15:0];
      wrap_nxt  = step[16];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      slow_q <= 1'b1;
      count  <= '0;
      wrap   <= 1'b0;
    end else begin
      slow_q <= Clk_Slow;
      count  <= count_nxt;
      wrap   <= wrap_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    case (digit_idx)
      2'd0:    nibble = count[3:0];
      2'd1:    nibble = count[7:4];
      2'd2:    nibble = count[11:8];
      default: nibble = count[15:12];
    endcase
  end

  // Blank a digit only when it and everything above it are zero; digit0 always shows.
  always_comb begin
    blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    case (digit_idx)
      2'd3:    blank = (count[15:12] == 4'd0);
      2'd2:    blank = (count[15:8] == 8'd0);
      2'd1:    blank = (count[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    an_nxt  = ~(4'b0001 << digit_idx);
    seg_nxt = blank ? 7'b1111111 : seg_decode(nibble);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      AN  <= 4'b1110;
      SEG <= 7'b1000000;
    end else begin
      AN  <= an_nxt;
      SEG <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_counter.sv
// Randomized self-checking bench for seven_seg_counter; the reference model
// keeps the count as a decimal integer and derives the scan slot from elapsed cycles.
module tb_seven_seg_counter;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  logic        CLK = 1'b0;
  logic        RST_N, Clk_Slow, en, clr, up_dn;
  logic [15:0] count;
  logic        wrap;
  logic [6:0]  SEG;
  logic [3:0]  AN;

  int n_vec = 0;
  int n_err = 0;

  int       m_cnt = 0;
  bit       m_wrap = 0;
  bit       m_prev = 1;
  int       m_t = 0;
  logic [6:0] m_seg = 7'b1000000;
  logic [3:0] m_an = 4'b1110;
  bit       cur_slow = 1;

  seven_seg_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .RST_N(RST_N), .Clk_Slow(Clk_Slow), .en(en), .clr(clr), .up_dn(up_dn),
    .count(count), .wrap(wrap), .SEG(SEG), .AN(AN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_exp(input int cnt, input int idx);
    int p = 1;
    for (int k = 0; k < idx; k++) p *= 10;
`ifdef SEG_LZ_BLANK_EN
    if (idx != 0 && cnt / p == 0) return 7'b1111111;
`endif
    return SEG_TBL[(cnt / p) % 10];
  endfunction

  // Drive one cycle of inputs, advance the model over the coming edge, check after it.
  task automatic step(input bit r, input bit s, input bit e, input bit c, input bit u);
    int idx;
    bit tk;
    RST_N = r; Clk_Slow = s; en = e; clr = c; up_dn = u;
    cur_slow = s;
    if (!r) begin
      m_cnt = 0; m_wrap = 0; m_prev = 1; m_t = 0;
      m_seg = 7'b1000000; m_an = 4'b1110;
    end else begin
      idx   = (m_t / SCAN_DIV) % 4;
      m_an  = ~(4'b0001 << idx);
      m_seg = seg_exp(m_cnt, idx);
      tk    = s && !m_prev;
      m_prev = s;
      m_wrap = 0;
      if (c) m_cnt = 0;
      else if (tk && e) begin
        if (u) begin
          m_wrap = (m_cnt == 9999);
          m_cnt  = (m_cnt + 1) % 10000;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt == 0) ? 9999 : m_cnt - 1;
        end
      end
      m_t++;
    end
    @(negedge CLK);
    chk("count", count, to_bcd(m_cnt));
    chk("wrap", wrap, m_wrap);
    chk("seg", SEG, m_seg);
    chk("an", AN, m_an);
  endtask

  task automatic tick_pulse(input bit u, input bit e);
    step(1, 1, e, 0, u);
    step(1, 0, e, 0, u);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, $urandom_range(0, 1));
  endtask

  initial begin
    // Reset with Clk_Slow high, then release while still high: no tick.
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("rst_an", AN, 4'b1110);
    chk("rst_seg", SEG, 7'b1000000);
    step(1, 1, 1, 0, 1);
    chk("no_tick", count, 16'h0000);
    step(1, 0, 1, 0, 1);

    for (int i = 0; i < 10; i++) tick_pulse(1, 1);
    chk("cnt10", count, 16'h0010);

    step(1, 0, 1, 1, 1);
    tick_pulse(0, 1);
    chk("dn_wrap", count, 16'h9999);
    tick_pulse(1, 1);
    chk("up_wrap", count, 16'h0000);
    tick_pulse(0, 1);
    tick_pulse(1, 1);

    for (int i = 0; i < 42; i++) tick_pulse(1, 1);
    for (int i = 0; i < 3; i++) tick_pulse(1, 0);
    chk("en_off", count, 16'h0042);
    step(1, 1, 1, 1, 1);
    chk("clr_tick", count, 16'h0000);
    step(1, 0, 1, 0, 1);

    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 1234; i++) tick_pulse(1, 1);
    chk("cnt1234", count, 16'h1234);
    hold(20);

    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 7; i++) tick_pulse(1, 1);
    hold(17);

    // Reset mid-scan, then resume.
    step(0, 0, 1, 0, 1);
    hold(10);

    for (int i = 0; i < 4000; i++) begin
      bit s = cur_slow;
      if ($urandom_range(0, 2) == 0) s = ~s;
      step($urandom_range(0, 199) != 0, s, $urandom_range(0, 7) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
